switch_conditioner: RTL and testbench

SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

---
 rtl/switch_pkg.sv | 21 ++
 rtl/switch_conditioner_if.sv | 13 +
 rtl/switch_debounce_ch.sv | 99 +++++++++
 rtl/switch_conditioner.sv | 106 ++++++++++
 tb/tb_switch_conditioner.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/switch_pkg.sv
// Shared types and default constants for the DIP-switch conditioner.
package switch_pkg;

    localparam int unsigned NumSwDefault          = 8;
    localparam int unsigned DebounceCyclesDefault = 1000;
    localparam int unsigned SyncStagesDefault     = 2;
    localparam int unsigned TxHalfPeriodDefault   = 16;

    typedef logic [1:0] sw_state_t;

    localparam sw_state_t StStableLo = 2'd0;
    localparam sw_state_t StWaitHi   = 2'd1;
    localparam sw_state_t StStableHi = 2'd2;
    localparam sw_state_t StWaitLo   = 2'd3;

    // Counter width that stays legal when the terminal count is 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/switch_conditioner_if.sv
// Change-event handshake between the switch conditioner and its consumer.
interface switch_conditioner_if #(
    parameter int unsigned NUM_SW = 8
) ();

    logic              evt_valid;
    logic              evt_ready;
    logic [NUM_SW-1:0] evt_mask;

    modport master (output evt_valid, output evt_mask, input evt_ready);
    modport slave  (input evt_valid, input evt_mask, output evt_ready);

endinterface

// File: rtl/switch_debounce_ch.sv
// One switch channel: synchronizer chain, debounce FSM and stable-sample counter.
module switch_debounce_ch
    import switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
    parameter int unsigned SYNC_STAGES     = SyncStagesDefault
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic sw_out,
    output logic chg
);

    localparam int unsigned      CntW    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0]  CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0]  CntOne  = CntW'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    sw_state_t              state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   chg_q, chg_d;
    logic                   sample;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], sw_in};
    assign sample = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        chg_d   = 1'b0;
        case (state_q)
            StStableLo: begin
                if (sample) begin
                    state_d = StWaitHi;
                    cnt_d   = CntOne;
                end
            end
            StWaitHi: begin
                if (!sample) begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StStableHi;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    chg_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StStableHi: begin
                if (!sample) begin
                    state_d = StWaitLo;
                    cnt_d   = CntOne;
                end
            end
            StWaitLo: begin
                if (sample) begin
                    state_d = StStableHi;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    chg_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StStableLo;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= StStableLo;
            cnt_q   <= '0;
            level_q <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            chg_q   <= chg_d;
        end
    end

    assign sw_out = level_q;
    assign chg    = chg_q;

endmodule

// File: rtl/switch_conditioner.sv
// DIP-switch conditioner: per-channel debounce, change-event accumulator and sfp_tx drive.
// Define SWITCH_TX_PATTERN_EN to make sfp_tx a square wave gated by sw_out[0].
module switch_conditioner
    import switch_pkg::*;
#(
    parameter int unsigned NUM_SW          = NumSwDefault,
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
    parameter int unsigned SYNC_STAGES     = SyncStagesDefault,
    parameter int unsigned TX_HALF_PERIOD  = TxHalfPeriodDefault
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SW-1:0]     sw_in,
    output logic [NUM_SW-1:0]     sw_out,
    switch_conditioner_if.master  evt,
    output logic                  sfp_tx
);

    if (NUM_SW < 1 || NUM_SW > 32) begin : g_bad_num_sw
        $error("NUM_SW must be in 1..32");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (TX_HALF_PERIOD < 1) begin : g_bad_tx_half
        $error("TX_HALF_PERIOD must be >= 1");
    end

    logic [NUM_SW-1:0] chg;
    logic [NUM_SW-1:0] pending_q, pending_d;
    logic              handshake;
    logic              sfp_tx_q, sfp_tx_d;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
        switch_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .sw_in  (sw_in[i]),
            .sw_out (sw_out[i]),
            .chg    (chg[i])
        );
    end

    // A change landing in the handshake cycle survives into the next event.
    assign handshake = evt.evt_valid && evt.evt_ready;

    always_comb begin
        pending_d = (handshake ? '0 : pending_q) | chg;
    end

    assign evt.evt_valid = |pending_q;
    assign evt.evt_mask  = pending_q;

`ifdef SWITCH_TX_PATTERN_EN
    localparam int unsigned     TxW    = cnt_width(TX_HALF_PERIOD);
    localparam logic [TxW-1:0]  TxLast = TxW'(TX_HALF_PERIOD - 1);

    logic [TxW-1:0] tx_cnt_q, tx_cnt_d;

    // Down-counter reloads on each toggle; a cleared counter toggles on the next edge.
    always_comb begin
        tx_cnt_d = tx_cnt_q;
        sfp_tx_d = sfp_tx_q;
        if (!sw_out[0]) begin
            tx_cnt_d = '0;
            sfp_tx_d = 1'b0;
        end else if (tx_cnt_q == '0) begin
            tx_cnt_d = TxLast;
            sfp_tx_d = ~sfp_tx_q;
        end else begin
            tx_cnt_d = tx_cnt_q - TxW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt_q <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
        end
    end
`else
    always_comb begin
        sfp_tx_d = sw_out[0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            sfp_tx_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            sfp_tx_q  <= sfp_tx_d;
        end
    end

    assign sfp_tx = sfp_tx_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: directed vector table, corner sequences, random vs reference model.
module tb_switch_conditioner;

    localparam int NSW  = 8;
    localparam int DB   = 4;
    localparam int SS   = 2;
    localparam int TXHP = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [NSW-1:0] sw_in;
    logic [NSW-1:0] sw_out;
    logic           sfp_tx;

    switch_conditioner_if #(.NUM_SW(NSW)) evt_if ();

    switch_conditioner #(
        .NUM_SW          (NSW),
        .DEBOUNCE_CYCLES (DB),
        .SYNC_STAGES     (SS),
        .TX_HALF_PERIOD  (TXHP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_in  (sw_in),
        .sw_out (sw_out),
        .evt    (evt_if),
        .sfp_tx (sfp_tx)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [NSW-1:0] sync_fifo[$];
    logic [NSW-1:0] win[$];
    logic [NSW-1:0] m_out, m_chg, m_pend;
    logic           m_tx;
    int             hi_run;

    typedef struct {
        logic [7:0] sw;
        logic       rdy;
        int         rep;
        logic [7:0] out;
        logic       v;
        logic [7:0] mask;
        logic       tx;
    } vec_t;

    vec_t tbl[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output level flips once the last DB synchronized samples all disagree with it.
    task automatic model_step(input logic [NSW-1:0] sw, input logic rdy, input logic r);
        logic [NSW-1:0] s, flip;
        logic           all_diff;
        if (r) begin
            sync_fifo = {};
            repeat (SS) sync_fifo.push_back('0);
            win    = {};
            m_out  = '0;
            m_chg  = '0;
            m_pend = '0;
            m_tx   = 1'b0;
            hi_run = 0;
        end else begin
`ifdef SWITCH_TX_PATTERN_EN
            if (m_out[0]) begin
                hi_run++;
                m_tx = (((hi_run - 1) / TXHP) % 2) == 0;
            end else begin
                hi_run = 0;
                m_tx   = 1'b0;
            end
`else
            m_tx = m_out[0];
`endif
            m_pend = ((m_pend != 0 && rdy) ? '0 : m_pend) | m_chg;
            sync_fifo.push_back(sw);
            s = sync_fifo.pop_front();
            win.push_back(s);
            if (win.size() > DB) void'(win.pop_front());
            flip = '0;
            if (win.size() == DB) begin
                for (int i = 0; i < NSW; i++) begin
                    all_diff = 1'b1;
                    foreach (win[j]) if (win[j][i] == m_out[i]) all_diff = 1'b0;
                    flip[i] = all_diff;
                end
            end
            m_chg = flip;
            m_out = m_out ^ flip;
        end
    endtask

    task automatic cycle(input logic [NSW-1:0] sw, input logic rdy, input logic r);
        sw_in            = sw;
        evt_if.evt_ready = rdy;
        rst              = r;
        @(posedge clk);
        model_step(sw, rdy, r);
        @(negedge clk);
    endtask

    initial begin
        logic [NSW-1:0] cur;
        logic           rr, rdy;

        tbl[0]  = '{8'h08, 1'b0, 5, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{8'h08, 1'b0, 1, 8'h08, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{8'h08, 1'b0, 1, 8'h08, 1'b1, 8'h08, 1'b0};
        tbl[3]  = '{8'h08, 1'b1, 1, 8'h08, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{8'h09, 1'b0, 5, 8'h08, 1'b0, 8'h00, 1'b0};
        tbl[5]  = '{8'h09, 1'b0, 1, 8'h09, 1'b0, 8'h00, 1'b0};
        tbl[6]  = '{8'h09, 1'b0, 1, 8'h09, 1'b1, 8'h01, 1'b1};
        tbl[7]  = '{8'h29, 1'b0, 5, 8'h09, 1'b1, 8'h01, 1'b1};
        tbl[8]  = '{8'h29, 1'b0, 1, 8'h29, 1'b1, 8'h01, 1'b1};
        tbl[9]  = '{8'h29, 1'b0, 1, 8'h29, 1'b1, 8'h21, 1'b1};
        tbl[10] = '{8'h29, 1'b1, 1, 8'h29, 1'b0, 8'h00, 1'b1};
        tbl[11] = '{8'h28, 1'b0, 1, 8'h29, 1'b0, 8'h00, 1'b1};
        tbl[12] = '{8'h2C, 1'b0, 4, 8'h29, 1'b0, 8'h00, 1'b1};
        tbl[13] = '{8'h2C, 1'b0, 1, 8'h28, 1'b0, 8'h00, 1'b1};
        tbl[14] = '{8'h2C, 1'b0, 1, 8'h2C, 1'b1, 8'h01, 1'b0};
        tbl[15] = '{8'h2C, 1'b1, 1, 8'h2C, 1'b1, 8'h04, 1'b0};
        tbl[16] = '{8'h2C, 1'b1, 1, 8'h2C, 1'b0, 8'h00, 1'b0};
        tbl[17] = '{8'h2D, 1'b1, 5, 8'h2C, 1'b0, 8'h00, 1'b0};
        tbl[18] = '{8'h2D, 1'b1, 1, 8'h2D, 1'b0, 8'h00, 1'b0};
        tbl[19] = '{8'h2D, 1'b1, 1, 8'h2D, 1'b1, 8'h01, 1'b1};
        tbl[20] = '{8'h2D, 1'b0, 1, 8'h2D, 1'b1, 8'h01, 1'b1};
        tbl[21] = '{8'h2D, 1'b1, 1, 8'h2D, 1'b0, 8'h00, 1'b1};

        sw_in            = '0;
        evt_if.evt_ready = 1'b0;
        rst              = 1'b1;
        @(negedge clk);
        cycle('0, 1'b0, 1'b1);
        cycle('0, 1'b0, 1'b1);
        check("reset_sw_out", 32'(sw_out), 32'h0);
        check("reset_evt_valid", 32'(evt_if.evt_valid), 32'h0);
        check("reset_evt_mask", 32'(evt_if.evt_mask), 32'h0);
        check("reset_sfp_tx", 32'(sfp_tx), 32'h0);

        foreach (tbl[r]) begin
            for (int k = 0; k < tbl[r].rep; k++) begin
                cycle(tbl[r].sw, tbl[r].rdy, 1'b0);
                check($sformatf("tbl%0d_sw_out", r), 32'(sw_out), 32'(tbl[r].out));
                check($sformatf("tbl%0d_evt_valid", r), 32'(evt_if.evt_valid), 32'(tbl[r].v));
                check($sformatf("tbl%0d_evt_mask", r), 32'(evt_if.evt_mask), 32'(tbl[r].mask));
`ifndef SWITCH_TX_PATTERN_EN
                check($sformatf("tbl%0d_sfp_tx", r), 32'(sfp_tx), 32'(tbl[r].tx));
`endif
            end
        end

        // Three-sample glitch on channel 1 must be rejected.
        for (int k = 0; k < 13; k++) begin
            cycle((k < 3) ? 8'h2F : 8'h2D, 1'b0, 1'b0);
            check("glitch_sw_out", 32'(sw_out), 32'h2D);
            check("glitch_evt_valid", 32'(evt_if.evt_valid), 32'h0);
        end

        // Reset two samples into a channel 7 debounce, then everything high reappears.
        for (int k = 0; k < 4; k++) cycle(8'hAD, 1'b0, 1'b0);
        check("middeb_sw_out", 32'(sw_out), 32'h2D);
        cycle(8'hAD, 1'b0, 1'b1);
        check("rst_abort_sw_out", 32'(sw_out), 32'h0);
        check("rst_abort_evt_valid", 32'(evt_if.evt_valid), 32'h0);
        for (int k = 1; k <= 7; k++) begin
            cycle(8'hAD, 1'b0, 1'b0);
            check("post_rst_sw_out", 32'(sw_out), (k >= SS + DB) ? 32'hAD : 32'h0);
            check("post_rst_evt_valid", 32'(evt_if.evt_valid), (k >= SS + DB + 1) ? 32'h1 : 32'h0);
            check("post_rst_evt_mask", 32'(evt_if.evt_mask), (k >= SS + DB + 1) ? 32'hAD : 32'h0);
        end
        cycle(8'hAD, 1'b1, 1'b0);
        check("post_rst_ack", 32'(evt_if.evt_valid), 32'h0);

        cur = 8'hAD;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(3) == 0) cur[$urandom_range(NSW - 1)] ^= 1'b1;
            rdy = 1'($urandom_range(1));
            rr  = ($urandom_range(399) == 0);
            cycle(cur, rdy, rr);
            check("rand_sw_out", 32'(sw_out), 32'(m_out));
            check("rand_evt_valid", 32'(evt_if.evt_valid), 32'(m_pend != 0));
            check("rand_evt_mask", 32'(evt_if.evt_mask), 32'(m_pend));
            check("rand_sfp_tx", 32'(sfp_tx), 32'(m_tx));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
